// File: rtl/blink_pkg.sv
// Shared definitions for the blink array: per-channel state encoding.
package blink_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_STOP = 2'b00,
        ST_ON   = 2'b01,
        ST_OFF  = 2'b10
    } state_t;

endpackage

// File: rtl/blink_array_controller_if.sv
// Control/indicator bundle between register logic (master) and the blink array (slave).
interface blink_array_controller_if
    import blink_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 8,
    parameter int REP_W    = 4
);
    logic [CHANNELS-1:0]         start;
    logic [CHANNELS-1:0]         en;
    logic [CHANNELS-1:0]         burst;
    logic [CHANNELS*CNT_W-1:0]   on_time;
    logic [CHANNELS*CNT_W-1:0]   off_time;
    logic [CHANNELS*REP_W-1:0]   reps;
    logic [CHANNELS-1:0]         light;
    logic [CHANNELS-1:0]         busy;
    logic [CHANNELS-1:0]         done;
    logic [CHANNELS*STATE_W-1:0] dbg_state;

    // start is a level sampled every clk edge; there is no ready back-pressure,
    // a start with en=1 is always accepted on the edge where it is seen.
    modport master (
        output start, en, burst, on_time, off_time, reps,
        input  light, busy, done, dbg_state
    );

    modport slave (
        input  start, en, burst, on_time, off_time, reps,
        output light, busy, done, dbg_state
    );

endinterface

// File: rtl/blink_channel.sv
// One blinker: STOP/ON/OFF FSM with its own period counter, rep counter and latched settings.
module blink_channel
    import blink_pkg::*;
#(
    parameter int CNT_W = 8,
    parameter int REP_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_en,
    input  logic             i_burst,
    input  logic [CNT_W-1:0] i_on_time,
    input  logic [CNT_W-1:0] i_off_time,
    input  logic [REP_W-1:0] i_reps,
    output logic             o_light,
    output logic             o_busy,
    output logic             o_done,
    output state_t           o_state
);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [REP_W-1:0] r_rep;
    logic [CNT_W-1:0] r_on;
    logic [CNT_W-1:0] r_off;
    logic [REP_W-1:0] r_reps;
    logic             r_burst;
    logic             r_light;
    logic             r_busy;
    logic             r_done;

    state_t           w_state_nx;
    logic [CNT_W-1:0] w_cnt_nx;
    logic [REP_W-1:0] w_rep_nx;
    logic             w_done_nx;
    logic             w_latch;
    logic [CNT_W-1:0] w_on_last;
    logic [CNT_W-1:0] w_off_last;
    logic [REP_W-1:0] w_reps_last;

    // Zero durations/counts behave as one, so the terminal count is never -1.
    assign w_on_last   = (r_on   == '0) ? '0 : r_on   - CNT_W'(1);
    assign w_off_last  = (r_off  == '0) ? '0 : r_off  - CNT_W'(1);
    assign w_reps_last = (r_reps == '0) ? '0 : r_reps - REP_W'(1);
    assign w_latch     = i_en & i_start;

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_rep_nx   = r_rep;
        w_done_nx  = 1'b0;
        // Priority: enable drop, then (re)start, then phase progress.
        if (!i_en) begin
            w_state_nx = ST_STOP;
            w_cnt_nx   = '0;
            w_rep_nx   = '0;
        end else if (i_start) begin
            w_state_nx = ST_ON;
            w_cnt_nx   = '0;
            w_rep_nx   = '0;
        end else begin
            case (r_state)
                ST_STOP: begin
                    w_cnt_nx = '0;
                    w_rep_nx = '0;
                end
                ST_ON: begin
                    if (r_cnt == w_on_last) begin
                        w_state_nx = ST_OFF;
                        w_cnt_nx   = '0;
                    end else begin
                        w_cnt_nx = r_cnt + CNT_W'(1);
                    end
                end
                ST_OFF: begin
                    if (r_cnt == w_off_last) begin
                        w_cnt_nx   = '0;
                        w_state_nx = ST_ON;
                        if (r_burst) begin
                            if (r_rep == w_reps_last) begin
                                w_state_nx = ST_STOP;
                                w_rep_nx   = '0;
                                w_done_nx  = 1'b1;
                            end else begin
                                w_rep_nx = r_rep + REP_W'(1);
                            end
                        end
                    end else begin
                        w_cnt_nx = r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    w_state_nx = ST_STOP;
                    w_cnt_nx   = '0;
                    w_rep_nx   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_STOP;
            r_cnt   <= '0;
            r_rep   <= '0;
            r_light <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_rep   <= w_rep_nx;
            r_light <= (w_state_nx == ST_ON);
            r_busy  <= (w_state_nx != ST_STOP);
            r_done  <= w_done_nx;
        end
    end

    // Settings only change on an accepted start.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_on    <= '0;
            r_off   <= '0;
            r_reps  <= '0;
            r_burst <= 1'b0;
        end else if (w_latch) begin
            r_on    <= i_on_time;
            r_off   <= i_off_time;
            r_reps  <= i_reps;
            r_burst <= i_burst;
        end
    end

    assign o_light = r_light;
    assign o_busy  = r_busy;
    assign o_done  = r_done;
    assign o_state = r_state;

endmodule

// File: rtl/blink_array_controller.sv
// Array of independent blink channels driving LED/indicator pins from packed control vectors.
module blink_array_controller
    import blink_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 8,
    parameter int REP_W    = 4
) (
    input logic                    clk,
    input logic                    reset,
    blink_array_controller_if.slave bus
);

    logic [CHANNELS-1:0]         w_light;
    logic [CHANNELS-1:0]         w_busy;
    logic [CHANNELS-1:0]         w_done;
    logic [CHANNELS*STATE_W-1:0] w_state;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        state_t w_ch_state;

        blink_channel #(
            .CNT_W (CNT_W),
            .REP_W (REP_W)
        ) u_channel (
            .i_clk      (clk),
            .i_rst_n    (reset),
            .i_start    (bus.start[g]),
            .i_en       (bus.en[g]),
            .i_burst    (bus.burst[g]),
            .i_on_time  (bus.on_time[g*CNT_W +: CNT_W]),
            .i_off_time (bus.off_time[g*CNT_W +: CNT_W]),
            .i_reps     (bus.reps[g*REP_W +: REP_W]),
            .o_light    (w_light[g]),
            .o_busy     (w_busy[g]),
            .o_done     (w_done[g]),
            .o_state    (w_ch_state)
        );

        assign w_state[g*STATE_W +: STATE_W] = w_ch_state;
    end

    assign bus.light     = w_light;
    assign bus.busy      = w_busy;
    assign bus.done      = w_done;
    assign bus.dbg_state = w_state;

endmodule

// File: tb/tb_blink_array_controller.sv
// Bench for blink_array_controller: directed scenarios plus random traffic against a cycle-position model.
module tb_blink_array_controller;
    import blink_pkg::*;

    localparam int CH = 4;
    localparam int CW = 8;
    localparam int RW = 4;
    localparam int EW = 3 * CH + CH * STATE_W;

    logic clk;
    logic rst_n;

    blink_array_controller_if #(.CHANNELS(CH), .CNT_W(CW), .REP_W(RW)) bif ();

    blink_array_controller #(.CHANNELS(CH), .CNT_W(CW), .REP_W(RW)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bif)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_err = 0;
    logic [EW-1:0] exp_q[$];

    // Model: a running channel is described by t = cycles since its start was
    // accepted; light follows t mod (on+off), a burst ends at t = reps*(on+off).
    bit m_act   [CH];
    int m_t     [CH];
    int m_on    [CH];
    int m_off   [CH];
    int m_reps  [CH];
    bit m_burst [CH];
    bit m_done  [CH];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int eff(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    task automatic model_clear();
        for (int c = 0; c < CH; c++) begin
            m_act[c]  = 1'b0;
            m_t[c]    = 0;
            m_done[c] = 1'b0;
        end
    endtask

    task automatic model_edge();
        for (int c = 0; c < CH; c++) begin
            m_done[c] = 1'b0;
            if (!bif.en[c]) begin
                m_act[c] = 1'b0;
            end else if (bif.start[c]) begin
                m_act[c]   = 1'b1;
                m_t[c]     = 0;
                m_on[c]    = eff(int'(bif.on_time[c*CW +: CW]));
                m_off[c]   = eff(int'(bif.off_time[c*CW +: CW]));
                m_reps[c]  = eff(int'(bif.reps[c*RW +: RW]));
                m_burst[c] = bif.burst[c];
            end else if (m_act[c]) begin
                m_t[c]++;
                if (m_burst[c] && m_t[c] == m_reps[c] * (m_on[c] + m_off[c])) begin
                    m_act[c]  = 1'b0;
                    m_done[c] = 1'b1;
                end
            end
        end
    endtask

    function automatic logic [EW-1:0] model_expect();
        logic [CH-1:0]         l, b, d;
        logic [CH*STATE_W-1:0] s;
        for (int c = 0; c < CH; c++) begin
            l[c] = m_act[c] && ((m_t[c] % (m_on[c] + m_off[c])) < m_on[c]);
            b[c] = m_act[c];
            d[c] = m_done[c];
            s[c*STATE_W +: STATE_W] = !m_act[c] ? ST_STOP : (l[c] ? ST_ON : ST_OFF);
        end
        return {s, d, b, l};
    endfunction

    task automatic check_outputs(input logic [EW-1:0] e);
        check_eq("light", 32'(bif.light), 32'(e[CH-1:0]));
        check_eq("busy",  32'(bif.busy),  32'(e[2*CH-1:CH]));
        check_eq("done",  32'(bif.done),  32'(e[3*CH-1:2*CH]));
        check_eq("state", 32'(bif.dbg_state), 32'(e[EW-1:3*CH]));
    endtask

    // ---------------- driver tasks ----------------
    // One clock: model consumes the inputs seen at the edge, DUT is sampled 1ns after.
    task automatic step();
        logic [EW-1:0] e;
        model_edge();
        exp_q.push_back(model_expect());
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_outputs(e);
        bif.start = '0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_ch(input int c, input int on, input int off, input int rp, input bit bu);
        bif.on_time[c*CW +: CW]  = CW'(on);
        bif.off_time[c*CW +: CW] = CW'(off);
        bif.reps[c*RW +: RW]     = RW'(rp);
        bif.burst[c]             = bu;
    endtask

    task automatic go(input int c);
        bif.start[c] = 1'b1;
        step();
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_clear();
        check_outputs('0);
        bif.start = '0;
        @(posedge clk);
        #1;
        check_outputs('0);
        rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int total;
        int guard;
        rst_n        = 1'b0;
        bif.start    = '0;
        bif.en       = '0;
        bif.burst    = '0;
        bif.on_time  = '0;
        bif.off_time = '0;
        bif.reps     = '0;
        model_clear();
        for (int c = 0; c < CH; c++) begin
            m_on[c] = 1; m_off[c] = 1; m_reps[c] = 1; m_burst[c] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        check_outputs('0);
        rst_n = 1'b1;

        // continuous 3/2
        bif.en[0] = 1'b1;
        set_ch(0, 3, 2, 0, 1'b0);
        go(0);
        run(20);

        // burst 2/1 x3
        set_ch(0, 2, 1, 3, 1'b1);
        go(0);
        run(12);

        // zero settings treated as one
        set_ch(0, 0, 0, 0, 1'b1);
        go(0);
        run(4);

        // enable drop mid-ON of a burst
        set_ch(0, 4, 2, 3, 1'b1);
        go(0);
        run(2);
        bif.en[0] = 1'b0;
        run(3);
        bif.en[0] = 1'b1;
        run(2);

        // on_time changed after start has no effect
        set_ch(0, 3, 2, 0, 1'b0);
        go(0);
        run(4);
        set_ch(0, 7, 9, 5, 1'b1);
        run(15);

        // restart on the final OFF cycle of a burst: no done
        set_ch(0, 1, 1, 2, 1'b1);
        go(0);
        total = 4;
        guard = 0;
        while (!(m_act[0] && m_t[0] == total - 1) && guard < 50) begin
            step();
            guard++;
        end
        check_eq("restart_reach", 32'(guard < 50), 32'd1);
        bif.start[0] = 1'b1;
        step();
        run(8);

        // multichannel, start on a disabled channel ignored
        bif.en = 4'b0111;
        set_ch(0, 1, 1, 0, 1'b0);
        set_ch(1, 2, 3, 0, 1'b0);
        set_ch(2, 5, 5, 0, 1'b0);
        set_ch(3, 255, 255, 0, 1'b0);
        bif.start = 4'b1111;
        step();
        run(3);
        bif.en[3] = 1'b1;
        go(3);
        run(1100);

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            for (int c = 0; c < CH; c++) begin
                bif.start[c] = ($urandom_range(0, 19) == 0);
                bif.en[c]    = ($urandom_range(0, 39) != 0);
                if ($urandom_range(0, 3) == 0)
                    set_ch(c, $urandom_range(0, 6), $urandom_range(0, 6),
                           $urandom_range(0, 4), 1'($urandom_range(0, 1)));
            end
            step();
        end

        // async reset during the last OFF cycle of a burst (done pending)
        bif.en = 4'b1111;
        set_ch(0, 1, 1, 1, 1'b1);
        go(0);
        step();
        check_eq("pre_reset_busy", 32'(bif.busy[0]), 32'd1);
        do_reset();
        run(3);
        set_ch(0, 2, 1, 1, 1'b1);
        go(0);
        run(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
